sram_1rwnr_model: RTL and testbench
===================================

# sram_1rwnr_model

Parametrised, single-clock behavioural SRAM macro model. It succeeds the fixed 32x2048 1RW1R model and generalises width, depth, byte-mask granularity, read-port count and read latency. It adds defined read-during-write policy, collision flags, read-valid strobes and an optional post-reset scrub. It sits wherever the accelerator needs a simulation/FPGA stand-in for an OpenRAM macro, such as weight and activation buffers.

## Interface
- DATA_WIDTH, 32: word width; must be a multiple of WMASK_GRAN.
- ADDR_WIDTH, 11: depth is 2**ADDR_WIDTH.
- WMASK_GRAN, 8: bits per write-mask bit; NUM_WMASKS = DATA_WIDTH/WMASK_GRAN.
- NUM_RPORTS, 1: number of read-only ports, 1..4.
- READ_LATENCY, 1: read latency in cycles, 1 or 2.
- RDW_MODE, RDW_OLD: read-port result when the same address is written on port 0 in the same cycle. RDW_OLD returns the pre-write word; RDW_NEW returns the merged word.
- SCRUB_ON_RESET, 1: zero the whole array after reset.
- clk  in  1  single clock, all edges rising.
- rst  in  1  synchronous, active-high reset.
- csb0  in  1  port 0 chip select, active low.
- web0  in  1  port 0 write enable, active low.
- wmask0  in  NUM_WMASKS  per-lane write enable.
- addr0  in  ADDR_WIDTH  port 0 address.
- din0  in  DATA_WIDTH  write data.
- dout0  out  DATA_WIDTH  port 0 read data.
- dvalid0  out  1  dout0 holds fresh read data this cycle.
- csb_r  in  NUM_RPORTS  read-port chip selects, active low.
- addr_r  in  NUM_RPORTS*ADDR_WIDTH  packed read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- dout_r  out  NUM_RPORTS*DATA_WIDTH  packed read data.
- dvalid_r  out  NUM_RPORTS  per-port read valid.
- collision  out  NUM_RPORTS  read port k hit the address port 0 wrote that cycle.
- busy  out  1  scrub in progress; all requests are ignored.

## Operation
- State machine, two states:
  - SCRUB: entered on rst when SCRUB_ON_RESET=1. Each cycle writes zero to mem[scrub_cnt] and increments scrub_cnt. After the write at scrub_cnt = 2**ADDR_WIDTH-1, the state moves to IDLE.
  - IDLE: entered on rst when SCRUB_ON_RESET=0. Normal operation.
- rst asserted mid-scrub restarts the scrub at address 0.
- rst does not clear array contents when SCRUB_ON_RESET=0.
- Port 0 access at a rising edge with !csb0 && !busy:
  - Write (!web0): lane i is updated from din0 if wmask0[i]=1; other lanes keep their value. wmask0=0 is a legal no-op write with no dvalid0.
  - Read (web0): returns mem[addr0]. A write never produces dvalid0.
- Read port k at a rising edge with !csb_r[k] && !busy: returns mem[addr_r[k]]. Read ports never write.
- Same-cycle hit, where read port k and a port 0 write target the same address:
  - collision[k] is asserted, aligned with dvalid_r[k].
  - Data returned follows RDW_MODE. Under RDW_NEW the returned word is the masked merge of old and new lanes.
  - Several read ports on one address all receive identical data.
- dout0 and dout_r hold their last value when no read completes; they are never driven to X.

## Timing
- Reset values: dout0=0, dout_r=0, dvalid0=0, dvalid_r=0, collision=0, busy=SCRUB_ON_RESET.
- Scrub:
  - busy is high for exactly 2**ADDR_WIDTH cycles after the first edge with rst=0.
  - The first request accepted is on the edge where busy=0 is sampled.
- Writes commit at the sampling edge. A read of the same address issued on the next edge sees the new data.
- Read latency:
  - READ_LATENCY=1: a request sampled at edge N has data and dvalid valid after edge N+1 is not required; data and dvalid become valid immediately after edge N and stay for one cycle.
  - READ_LATENCY=2: data and dvalid are valid after edge N+1. The array read is still performed at edge N, so RDW semantics are unchanged.
- Full throughput: one request per port per cycle, back to back, no stalls.

## Structure
- Package sram_model_pkg holds:
  - enum rdw_mode_e {RDW_OLD, RDW_NEW};
  - enum scrub_state_e {ST_IDLE, ST_SCRUB};
  - function merge_lanes(old, new, mask, gran) for masked merge.
- Sub-module sram_rd_pipe: the per-port output pipeline (1 or 2 stages) carrying data, valid and collision with hold-last-value behaviour. It is instantiated NUM_RPORTS+1 times.
- Add an elaboration-time check that DATA_WIDTH % WMASK_GRAN == 0 and READ_LATENCY is in {1,2}.

## Test plan
- Scrub, ADDR_WIDTH=4: release rst, then check busy is high for 16 cycles. Read all 16 addresses; each returns 0x00000000 with dvalid.
- Masked write: write 0xAABBCCDD to addr 3 with mask 0xF, then 0x11223344 with mask 0x5. Read addr 3 returns 0xAA22CC44.
- Read-during-write: mem[5]=0x1, then in one cycle write 0x2 to addr 5 on port 0 and read addr 5 on read port 0.
  - RDW_OLD: returns 0x1 with collision=1.
  - RDW_NEW: returns 0x2 with collision=1.
- Latency: READ_LATENCY=2, NUM_RPORTS=2, back-to-back reads of addrs 0..7 on all ports. Data and dvalid arrive 2 cycles after each request, in order, with no gaps.
- Reset mid-scrub: assert rst at scrub_cnt=7. busy stays high and a full 16-cycle scrub restarts. Outputs are 0 during rst.
- Requests while busy: csb0=0 write of 0xFF to addr 2 during scrub. No dvalid is produced, and after scrub addr 2 reads 0.

Source files
------------

// File: rtl/sram_1rwnr_model_pkg.sv
// Shared types and helpers for the parametrised 1RW + N-read SRAM model.
// Holds read-during-write policy, scrub FSM states and the lane merge.
package sram_model_pkg;

  typedef enum logic {RDW_OLD, RDW_NEW} rdw_mode_e;
  typedef enum logic {ST_IDLE, ST_SCRUB} scrub_state_e;

  localparam int MAX_DW = 512;
  localparam int MAX_AW = $clog2(MAX_DW);

  // Lane i of the result comes from new_w when mask[i] is set.
  function automatic logic [MAX_DW-1:0] merge_lanes(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_DW-1:0] mask,
    input int                gran
  );
    logic [MAX_DW-1:0] r;
    for (int b = 0; b < MAX_DW; b++) begin
      r[MAX_AW'(b)] = mask[MAX_AW'(b / gran)] ?
                      new_w[MAX_AW'(b)] : old_w[MAX_AW'(b)];
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read output pipeline, 1 or 2 stages; data holds its last valid value.
// Payload is generic so read ports can carry the collision flag with it.
module sram_rd_pipe #(
  parameter int W       = 32,
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         v1;
  logic [W-1:0] d1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) d1 <= in_data;
    end
  end

  if (LATENCY == 2) begin : g_two
    logic         v2;
    logic [W-1:0] d2;

    always_ff @(posedge clk) begin
      if (rst) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        if (v1) d2 <= d1;
      end
    end

    assign out_valid = v2;
    assign out_data  = d2;
  end else begin : g_one
    assign out_valid = v1;
    assign out_data  = d1;
  end

endmodule

// File: rtl/sram_1rwnr_model.sv
// Behavioural SRAM: one read/write port plus NUM_RPORTS read ports,
// with selectable read-during-write policy and optional reset scrub.
module sram_1rwnr_model
  import sram_model_pkg::*;
#(
  parameter int        DATA_WIDTH     = 32,
  parameter int        ADDR_WIDTH     = 11,
  parameter int        WMASK_GRAN     = 8,
  parameter int        NUM_RPORTS     = 1,
  parameter int        READ_LATENCY   = 1,
  parameter rdw_mode_e RDW_MODE       = RDW_OLD,
  parameter bit        SCRUB_ON_RESET = 1'b1,
  localparam int       NUM_WMASKS     = DATA_WIDTH / WMASK_GRAN
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             csb0,
  input  logic                             web0,
  input  logic [NUM_WMASKS-1:0]            wmask0,
  input  logic [ADDR_WIDTH-1:0]            addr0,
  input  logic [DATA_WIDTH-1:0]            din0,
  output logic [DATA_WIDTH-1:0]            dout0,
  output logic                             dvalid0,
  input  logic [NUM_RPORTS-1:0]            csb_r,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] addr_r,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] dout_r,
  output logic [NUM_RPORTS-1:0]            dvalid_r,
  output logic [NUM_RPORTS-1:0]            collision,
  output logic                             busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int DW    = DATA_WIDTH;

  if (DATA_WIDTH % WMASK_GRAN != 0 || DATA_WIDTH > MAX_DW) begin : g_bad_w
    $error("sram_1rwnr_model: bad DATA_WIDTH/WMASK_GRAN");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_lat
    $error("sram_1rwnr_model: READ_LATENCY must be 1 or 2");
  end
  if (NUM_RPORTS < 1 || NUM_RPORTS > 4) begin : g_bad_np
    $error("sram_1rwnr_model: NUM_RPORTS must be 1..4");
  end

  logic [DW-1:0]         mem [DEPTH];
  scrub_state_e          state;
  scrub_state_e          state_nx;
  logic [ADDR_WIDTH-1:0] scrub_cnt;
  logic                  scrub_we;
  logic                  acc0;
  logic                  wr_en;
  logic                  rd0;
  logic [DW-1:0]         wr_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCRUB_ON_RESET ? ST_SCRUB : ST_IDLE;
      scrub_cnt <= '0;
    end else begin
      state <= state_nx;
      if (scrub_we) scrub_cnt <= scrub_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_SCRUB: if (&scrub_cnt) state_nx = ST_IDLE;
      ST_IDLE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == ST_SCRUB);
    scrub_we = busy && !rst;
  end

  assign acc0    = !rst && !busy && !csb0;
  assign wr_en   = acc0 && !web0;
  assign rd0     = acc0 && web0;
  assign wr_word = DW'(merge_lanes(MAX_DW'(mem[addr0]), MAX_DW'(din0),
                                   MAX_DW'(wmask0), WMASK_GRAN));

  always_ff @(posedge clk) begin
    if (scrub_we)   mem[scrub_cnt] <= '0;
    else if (wr_en) mem[addr0]     <= wr_word;
  end

  sram_rd_pipe #(.W(DW), .LATENCY(READ_LATENCY)) u_pipe0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd0),
    .in_data   (mem[addr0]),
    .out_valid (dvalid0),
    .out_data  (dout0)
  );

  for (genvar k = 0; k < NUM_RPORTS; k++) begin : g_rport
    logic [ADDR_WIDTH-1:0] ra;
    logic                  racc;
    logic                  hit;
    logic [DW-1:0]         rword;
    logic                  pv;
    logic [DW:0]           pd;

    assign ra    = addr_r[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign racc  = !rst && !busy && !csb_r[k];
    assign hit   = wr_en && (ra == addr0);
    // Array is read before this edge's write lands: old word unless RDW_NEW.
    assign rword = (hit && RDW_MODE == RDW_NEW) ? wr_word : mem[ra];

    sram_rd_pipe #(.W(DW + 1), .LATENCY(READ_LATENCY)) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (racc),
      .in_data   ({hit, rword}),
      .out_valid (pv),
      .out_data  (pd)
    );

    assign dout_r[k*DW +: DW] = pd[DW-1:0];
    assign dvalid_r[k]        = pv;
    assign collision[k]       = pv & pd[DW];
  end

endmodule

// File: tb/tb_sram_1rwnr_model.sv
// Bench: two shared-stimulus instances (latency 1 / RDW_OLD, latency 2 /
// RDW_NEW) against an array reference model plus directed checks.
module tb_sram_1rwnr_model;
  import sram_model_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        csb0, web0;
  logic [3:0]  wmask0;
  logic [3:0]  addr0;
  logic [31:0] din0;
  logic [1:0]  csb_r;
  logic [7:0]  addr_r;

  logic [31:0] a_dout0, b_dout0;
  logic        a_dvalid0, b_dvalid0;
  logic [63:0] a_dout_r, b_dout_r;
  logic [1:0]  a_dvalid_r, b_dvalid_r;
  logic [1:0]  a_coll, b_coll;
  logic        a_busy, b_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_1rwnr_model #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .WMASK_GRAN(8), .NUM_RPORTS(2),
    .READ_LATENCY(1), .RDW_MODE(RDW_OLD), .SCRUB_ON_RESET(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(a_dout0), .dvalid0(a_dvalid0),
    .csb_r(csb_r), .addr_r(addr_r), .dout_r(a_dout_r),
    .dvalid_r(a_dvalid_r), .collision(a_coll), .busy(a_busy)
  );

  sram_1rwnr_model #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .WMASK_GRAN(8), .NUM_RPORTS(2),
    .READ_LATENCY(2), .RDW_MODE(RDW_NEW), .SCRUB_ON_RESET(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(b_dout0), .dvalid0(b_dvalid0),
    .csb_r(csb_r), .addr_r(addr_r), .dout_r(b_dout_r),
    .dvalid_r(b_dvalid_r), .collision(b_coll), .busy(b_busy)
  );

  // Reference state: array contents, scrub progress, expected outputs.
  logic [31:0] m_mem [16];
  int          busy_left;
  int          scrub_idx;
  logic        ea_v0, eb_v0, sb_v0;
  logic [31:0] ea_d0, eb_d0, sb_d0;
  logic [1:0]  ea_vr, eb_vr, sb_vr;
  logic [1:0]  ea_col, eb_col, sb_col;
  logic [31:0] ea_dr [2];
  logic [31:0] eb_dr [2];
  logic [31:0] sb_dr [2];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic        busy_now, acc0, wr, rd, acc, hit;
    logic [31:0] old0, merged;
    logic [3:0]  ra;
    if (rst) begin
      busy_left = 16;
      scrub_idx = 0;
      ea_v0 = 0; eb_v0 = 0; sb_v0 = 0;
      ea_d0 = 0; eb_d0 = 0; sb_d0 = 0;
      ea_vr = 0; eb_vr = 0; sb_vr = 0;
      ea_col = 0; eb_col = 0; sb_col = 0;
      for (int k = 0; k < 2; k++) begin
        ea_dr[k] = 0; eb_dr[k] = 0; sb_dr[k] = 0;
      end
      return;
    end
    busy_now = (busy_left > 0);
    acc0 = !busy_now && !csb0;
    wr   = acc0 && !web0;
    rd   = acc0 && web0;
    old0 = m_mem[addr0];
    for (int i = 0; i < 4; i++)
      merged[i*8 +: 8] = wmask0[i] ? din0[i*8 +: 8] : old0[i*8 +: 8];
    eb_v0 = sb_v0;
    if (sb_v0) eb_d0 = sb_d0;
    eb_vr  = sb_vr;
    eb_col = sb_col;
    for (int k = 0; k < 2; k++)
      if (sb_vr[k]) eb_dr[k] = sb_dr[k];
    ea_v0 = rd;
    sb_v0 = rd;
    if (rd) begin
      ea_d0 = old0;
      sb_d0 = old0;
    end
    for (int k = 0; k < 2; k++) begin
      ra  = addr_r[k*4 +: 4];
      acc = !busy_now && !csb_r[k];
      hit = wr && (ra == addr0);
      ea_vr[k]  = acc;
      sb_vr[k]  = acc;
      ea_col[k] = acc && hit;
      sb_col[k] = acc && hit;
      if (acc) begin
        ea_dr[k] = m_mem[ra];
        sb_dr[k] = hit ? merged : m_mem[ra];
      end
    end
    if (busy_now) begin
      m_mem[scrub_idx] = 0;
      scrub_idx++;
      busy_left--;
    end else if (wr) begin
      m_mem[addr0] = merged;
    end
  endtask

  task automatic check_all();
    logic eb;
    eb = (busy_left > 0);
    chk("a_busy", 64'(a_busy), 64'(eb));
    chk("a_dvalid0", 64'(a_dvalid0), 64'(ea_v0));
    chk("a_dout0", 64'(a_dout0), 64'(ea_d0));
    chk("a_dvalid_r", 64'(a_dvalid_r), 64'(ea_vr));
    chk("a_dout_r", a_dout_r, {ea_dr[1], ea_dr[0]});
    chk("a_collision", 64'(a_coll), 64'(ea_col));
    chk("b_busy", 64'(b_busy), 64'(eb));
    chk("b_dvalid0", 64'(b_dvalid0), 64'(eb_v0));
    chk("b_dout0", 64'(b_dout0), 64'(eb_d0));
    chk("b_dvalid_r", 64'(b_dvalid_r), 64'(eb_vr));
    chk("b_dout_r", b_dout_r, {eb_dr[1], eb_dr[0]});
    chk("b_collision", 64'(b_coll), 64'(eb_col));
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    csb0  = 1'b1;
    web0  = 1'b1;
    csb_r = 2'b11;
  endtask

  task automatic wr0(input logic [3:0] a, input logic [31:0] d,
                     input logic [3:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
  endtask

  task automatic rd0(input logic [3:0] a);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a;
  endtask

  task automatic count_scrub(input string tag);
    int n = 0;
    while (a_busy && n < 40) begin
      if (n < 5) wr0(4'd2, 32'hFF, 4'hF);
      else idle();
      cyc();
      n++;
    end
    idle();
    chk(tag, 64'(n), 64'd16);
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd0(4'(a));
      csb_r  = 2'b00;
      addr_r = {4'(15 - a), 4'(a)};
      cyc();
      chk(tag, {31'd0, a_dvalid0, a_dout0}, 64'h1_0000_0000);
    end
    idle();
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; idle();
    wmask0 = 0; addr0 = 0; din0 = 0; addr_r = 0;
    cyc();
    cyc();
    chk("rst_busy", 64'(a_busy), 64'd1);
    rst = 1'b0;
    count_scrub("scrub_len");
    read_all_zero("scrub_rd");

    wr0(4'd3, 32'hAABBCCDD, 4'hF); cyc();
    wr0(4'd3, 32'h11223344, 4'h5); cyc();
    rd0(4'd3); cyc();
    chk("mask_a", 64'(a_dout0), 64'hAA22CC44);
    idle(); cyc();
    chk("mask_b", 64'(b_dout0), 64'hAA22CC44);

    wr0(4'd5, 32'h1, 4'hF); cyc();
    wr0(4'd5, 32'h2, 4'hF);
    csb_r = 2'b00; addr_r = {4'd5, 4'd5};
    cyc();
    chk("rdw_old", a_dout_r, {32'h1, 32'h1});
    chk("rdw_old_col", 64'(a_coll), 64'd3);
    idle(); cyc();
    chk("rdw_new", b_dout_r, {32'h2, 32'h2});
    chk("rdw_new_col", 64'(b_coll), 64'd3);

    for (int a = 0; a < 8; a++) begin
      wr0(4'(a), 32'h100 + 32'(a), 4'hF); cyc();
    end
    for (int a = 0; a < 8; a++) begin
      idle();
      csb_r = 2'b00; addr_r = {4'(a), 4'(a)};
      cyc();
      chk("lat1_data", a_dout_r, {2{32'h100 + 32'(a)}});
      if (a > 0) begin
        chk("lat2_valid", 64'(b_dvalid_r), 64'd3);
        chk("lat2_data", b_dout_r, {2{32'h100 + 32'(a - 1)}});
      end
    end
    idle(); cyc();
    chk("lat2_last", b_dout_r, {2{32'h107}});
    cyc();
    chk("lat2_gap", 64'(b_dvalid_r), 64'd0);

    for (int i = 0; i < 400; i++) begin
      csb0   = ($urandom_range(0, 3) == 0);
      web0   = $urandom_range(0, 1) == 1;
      wmask0 = 4'($urandom);
      addr0  = 4'($urandom_range(0, 15));
      din0   = $urandom;
      csb_r  = 2'($urandom);
      for (int k = 0; k < 2; k++)
        addr_r[k*4 +: 4] = ($urandom_range(0, 2) == 0) ?
                           addr0 : 4'($urandom_range(0, 15));
      cyc();
    end

    idle();
    rst = 1'b1; cyc();
    rst = 1'b0;
    repeat (7) cyc();
    rst = 1'b1; rd0(4'd1); csb_r = 2'b00;
    cyc();
    chk("midrst_out", {a_dout0, 30'd0, a_dvalid0, b_dvalid0},
        64'd0);
    chk("midrst_busy", 64'(a_busy), 64'd1);
    rst = 1'b0; idle();
    count_scrub("rescrub_len");
    read_all_zero("rescrub_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
